// File: rtl/logic_capture_pkg.sv
// Shared types and default sizing for the logic-analyzer capture arbiter.
package logic_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    typedef logic pod_t;

    localparam int DEF_DATA_WIDTH  = 128;
    localparam int DEF_ADDR_WIDTH  = 28;
    localparam int DEF_BURST_LEN   = 8;
    localparam int DEF_COUNT_WIDTH = 10;

endpackage

// File: rtl/logic_capture_arbiter_rr_grant.sv
// Two-way round-robin pick: a lone eligible pod wins; on a tie the pod that
// did not win last time gets the port.
module capture_rr_grant
    import logic_capture_pkg::*;
(
    input  logic [1:0] i_eligible,
    input  logic       i_last_grant,
    output logic       o_grant,
    output logic       o_any
);

    pod_t w_pick;

    always_comb begin
        w_pick = 1'b0;
        case (i_eligible)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = ~i_last_grant;
            default: w_pick = 1'b0;
        endcase
    end

    assign o_grant = w_pick;
    assign o_any   = |i_eligible;

endmodule

// File: rtl/logic_capture_arbiter.sv
// Shares the capture-RAM write port between pods LA0/LA1 in fixed bursts,
// keeping a ring-buffer write pointer per pod and draining on trigger flush.
module logic_capture_arbiter
    import logic_capture_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                        clk_ram_2x,
    input  logic                        rst_n,
    input  logic                        trig_rst,
    input  logic                        capture_flush,
    input  logic [2*COUNT_WIDTH-1:0]    fifo_count,
    input  logic [2*DATA_WIDTH-1:0]     fifo_data,
    output logic [1:0]                  fifo_rd_en,
    output logic                        ram_cmd_valid,
    input  logic                        ram_cmd_ready,
    output logic [ADDR_WIDTH-1:0]       ram_cmd_addr,
    output logic                        ram_wr_valid,
    input  logic                        ram_wr_ready,
    output logic [DATA_WIDTH-1:0]       ram_wr_data,
    output logic                        ram_wr_last,
    output logic [2*(ADDR_WIDTH-1)-1:0] wr_ptr,
    output logic [1:0]                  wrapped,
    output logic                        flush_done,
    output logic                        busy
);

    localparam int PTR_W = ADDR_WIDTH - 1;
    localparam logic [COUNT_WIDTH-1:0] BURST_C     = COUNT_WIDTH'(BURST_LEN);
    localparam logic [COUNT_WIDTH-1:0] LAST_BEAT_C = COUNT_WIDTH'(BURST_LEN - 1);
    localparam logic [PTR_W:0]         BURST_INC   = (PTR_W + 1)'(BURST_LEN);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    pod_t                   r_grant;
    pod_t                   r_last_grant;
    logic [COUNT_WIDTH-1:0] r_beats_real;
    logic [COUNT_WIDTH-1:0] r_beat;
    logic [PTR_W-1:0]       r_wr_ptr [2];
    logic [1:0]             r_wrapped;
    logic                   r_flush_pending;
    logic                   r_flush_done;

    logic [COUNT_WIDTH-1:0] w_cnt [2];
    logic [DATA_WIDTH-1:0]  w_data [2];
    logic [1:0]             w_eligible;
    logic                   w_grant;
    logic                   w_any;
    logic [COUNT_WIDTH-1:0] w_sel_cnt;
    logic [COUNT_WIDTH-1:0] w_beats;
    logic                   w_real_beat;
    logic                   w_last_beat;
    logic                   w_flush_clear;
    logic [PTR_W-1:0]       w_ptr_sum;
    logic                   w_ptr_carry;

    assign w_cnt[0]  = fifo_count[COUNT_WIDTH-1:0];
    assign w_cnt[1]  = fifo_count[2*COUNT_WIDTH-1:COUNT_WIDTH];
    assign w_data[0] = fifo_data[DATA_WIDTH-1:0];
    assign w_data[1] = fifo_data[2*DATA_WIDTH-1:DATA_WIDTH];

    // While a flush is pending any non-empty pod may go, even with a partial burst.
    assign w_eligible[0] = (w_cnt[0] >= BURST_C) || (r_flush_pending && (w_cnt[0] != '0));
    assign w_eligible[1] = (w_cnt[1] >= BURST_C) || (r_flush_pending && (w_cnt[1] != '0));

    capture_rr_grant u_rr_grant (
        .i_eligible   (w_eligible),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any        (w_any)
    );

    assign w_sel_cnt     = w_cnt[w_grant];
    assign w_beats       = (w_sel_cnt >= BURST_C) ? BURST_C : w_sel_cnt;
    assign w_real_beat   = (r_beat < r_beats_real);
    assign w_last_beat   = (r_beat == LAST_BEAT_C);
    assign w_flush_clear = (r_state == ST_IDLE) && r_flush_pending &&
                           (w_cnt[0] == '0) && (w_cnt[1] == '0);

    // Carry out of the pod-region offset marks a ring-buffer wrap.
    assign {w_ptr_carry, w_ptr_sum} = {1'b0, r_wr_ptr[r_grant]} + BURST_INC;

    always_comb begin
        w_state_nxt   = r_state;
        ram_cmd_valid = 1'b0;
        ram_cmd_addr  = '0;
        ram_wr_valid  = 1'b0;
        ram_wr_data   = '0;
        ram_wr_last   = 1'b0;
        fifo_rd_en    = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_any) w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                ram_cmd_valid = 1'b1;
                ram_cmd_addr  = {r_grant, r_wr_ptr[r_grant]};
                if (ram_cmd_ready) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                ram_wr_valid = 1'b1;
                ram_wr_last  = w_last_beat;
                if (w_real_beat) ram_wr_data = w_data[r_grant];
                fifo_rd_en[r_grant] = ram_wr_ready && w_real_beat;
                if (ram_wr_ready && w_last_beat) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (trig_rst) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
        if (!rst_n) begin
            r_grant         <= 1'b0;
            r_last_grant    <= 1'b1;
            r_beats_real    <= '0;
            r_beat          <= '0;
            r_wr_ptr[0]     <= '0;
            r_wr_ptr[1]     <= '0;
            r_wrapped       <= 2'b00;
            r_flush_pending <= 1'b0;
            r_flush_done    <= 1'b0;
        end else if (trig_rst) begin
            // Mid-burst abort is safe: the RAM controller is cleared by the same strobe.
            r_grant         <= 1'b0;
            r_last_grant    <= 1'b1;
            r_beats_real    <= '0;
            r_beat          <= '0;
            r_wr_ptr[0]     <= '0;
            r_wr_ptr[1]     <= '0;
            r_wrapped       <= 2'b00;
            r_flush_pending <= 1'b0;
            r_flush_done    <= 1'b0;
        end else begin
            r_flush_done <= w_flush_clear;
            if (w_flush_clear)      r_flush_pending <= 1'b0;
            else if (capture_flush) r_flush_pending <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_grant;
                        r_beats_real <= w_beats;
                    end
                end
                ST_CMD: begin
                    if (ram_cmd_ready) r_beat <= '0;
                end
                ST_DATA: begin
                    if (ram_wr_ready) begin
                        r_beat <= r_beat + COUNT_WIDTH'(1);
                        if (w_last_beat) begin
                            r_wr_ptr[r_grant] <= w_ptr_sum;
                            if (w_ptr_carry) r_wrapped[r_grant] <= 1'b1;
                            r_last_grant <= r_grant;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_ptr     = {r_wr_ptr[1], r_wr_ptr[0]};
    assign wrapped    = r_wrapped;
    assign flush_done = r_flush_done;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_logic_capture_arbiter.sv
// Randomized bench for logic_capture_arbiter: pod FIFOs modelled as queues,
// RAM port checked against a burst-level reference model every cycle.
module tb_logic_capture_arbiter;

    localparam int DW     = 32;
    localparam int AW     = 10;
    localparam int BL     = 8;
    localparam int CW     = 10;
    localparam int PW     = AW - 1;
    localparam int REGION = 1 << PW;

    logic              clk;
    logic              rst_n;
    logic              trig_rst;
    logic              capture_flush;
    logic [2*CW-1:0]   fifo_count;
    logic [2*DW-1:0]   fifo_data;
    logic [1:0]        fifo_rd_en;
    logic              ram_cmd_valid;
    logic              ram_cmd_ready;
    logic [AW-1:0]     ram_cmd_addr;
    logic              ram_wr_valid;
    logic              ram_wr_ready;
    logic [DW-1:0]     ram_wr_data;
    logic              ram_wr_last;
    logic [2*PW-1:0]   wr_ptr;
    logic [1:0]        wrapped;
    logic              flush_done;
    logic              busy;

    logic_capture_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .BURST_LEN   (BL),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk_ram_2x    (clk),
        .rst_n         (rst_n),
        .trig_rst      (trig_rst),
        .capture_flush (capture_flush),
        .fifo_count    (fifo_count),
        .fifo_data     (fifo_data),
        .fifo_rd_en    (fifo_rd_en),
        .ram_cmd_valid (ram_cmd_valid),
        .ram_cmd_ready (ram_cmd_ready),
        .ram_cmd_addr  (ram_cmd_addr),
        .ram_wr_valid  (ram_wr_valid),
        .ram_wr_ready  (ram_wr_ready),
        .ram_wr_data   (ram_wr_data),
        .ram_wr_last   (ram_wr_last),
        .wr_ptr        (wr_ptr),
        .wrapped       (wrapped),
        .flush_done    (flush_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // pod FIFO contents (what the DUT sees) and words still owed to RAM
    logic [DW-1:0] fq [2][$];
    logic [DW-1:0] eq [2][$];
    int            seq [2];

    // reference model of the arbiter's externally visible behaviour
    int  m_phase;   // 0 idle, 1 command, 2 data
    bit  m_pod;
    int  m_real;
    int  m_beat;
    int  m_ptr [2];
    bit  m_wrap [2];
    bit  m_last;
    bit  m_pend;
    bit  m_fd_exp;

    int  fd_cnt;
    int  pops [2];
    int  bursts;
    int  last_idx;
    bit  grants [$];
    bit  pop_flag [2];
    bit  rnd_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        n_chk++;
        if (obs !== expd) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_beat   = 0;
        m_real   = 0;
        m_ptr[0] = 0;
        m_ptr[1] = 0;
        m_wrap[0] = 1'b0;
        m_wrap[1] = 1'b0;
        m_last   = 1'b1;
        m_pend   = 1'b0;
        m_fd_exp = 1'b0;
    endtask

    task automatic refresh();
        for (int p = 0; p < 2; p++) begin
            fifo_count[p*CW +: CW] = CW'(fq[p].size());
            fifo_data[p*DW +: DW]  = (fq[p].size() > 0) ? fq[p][0] : DW'($urandom);
        end
    endtask

    task automatic push(input int p, input int n);
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = DW'(((p + 1) << 24) + seq[p]);
            seq[p]++;
            fq[p].push_back(v);
            eq[p].push_back(v);
        end
        refresh();
    endtask

    task automatic monitor();
        int            cnt [2];
        bit            elig [2];
        bit            clr;
        logic [1:0]    exp_rd;
        logic [DW-1:0] exp_data;
        int            sum;
        cnt[0] = int'(fifo_count[CW-1:0]);
        cnt[1] = int'(fifo_count[2*CW-1:CW]);
        clr    = 1'b0;

        check("flush_done", 64'(flush_done), 64'(m_fd_exp));
        if (flush_done) fd_cnt++;
        m_fd_exp = 1'b0;
        check("wr_ptr0", 64'(wr_ptr[PW-1:0]), 64'(m_ptr[0]));
        check("wr_ptr1", 64'(wr_ptr[2*PW-1:PW]), 64'(m_ptr[1]));
        check("wrapped", 64'(wrapped), 64'({m_wrap[1], m_wrap[0]}));
        for (int p = 0; p < 2; p++) begin
            pop_flag[p] = fifo_rd_en[p];
            if (fifo_rd_en[p]) pops[p]++;
        end

        case (m_phase)
            0: begin
                check("cmd_valid_idle", 64'(ram_cmd_valid), 64'd0);
                check("wr_valid_idle", 64'(ram_wr_valid), 64'd0);
                check("rd_en_idle", 64'(fifo_rd_en), 64'd0);
                for (int p = 0; p < 2; p++)
                    elig[p] = (cnt[p] >= BL) || (m_pend && cnt[p] > 0);
                if (elig[0] || elig[1]) begin
                    m_pod   = (elig[0] && elig[1]) ? !m_last : elig[1];
                    m_real  = (cnt[m_pod] < BL) ? cnt[m_pod] : BL;
                    m_phase = 1;
                end else if (m_pend) begin
                    clr      = 1'b1;
                    m_pend   = 1'b0;
                    m_fd_exp = 1'b1;
                end
            end
            1: begin
                check("cmd_valid", 64'(ram_cmd_valid), 64'd1);
                check("cmd_addr", 64'(ram_cmd_addr), 64'((int'(m_pod) << PW) | m_ptr[m_pod]));
                check("wr_valid_cmd", 64'(ram_wr_valid), 64'd0);
                check("rd_en_cmd", 64'(fifo_rd_en), 64'd0);
                if (ram_cmd_ready) begin
                    grants.push_back(ram_cmd_addr[AW-1]);
                    m_phase = 2;
                    m_beat  = 0;
                end
            end
            default: begin
                check("wr_valid", 64'(ram_wr_valid), 64'd1);
                check("cmd_valid_data", 64'(ram_cmd_valid), 64'd0);
                exp_data = (m_beat < m_real && eq[m_pod].size() > 0) ? eq[m_pod][0] : '0;
                check("wr_data", 64'(ram_wr_data), 64'(exp_data));
                check("wr_last", 64'(ram_wr_last), 64'(m_beat == BL - 1));
                exp_rd = 2'b00;
                if (ram_wr_ready && m_beat < m_real) exp_rd[m_pod] = 1'b1;
                check("rd_en", 64'(fifo_rd_en), 64'(exp_rd));
                if (ram_wr_ready) begin
                    if (ram_wr_last) last_idx = m_beat;
                    if (m_beat < m_real && eq[m_pod].size() > 0) void'(eq[m_pod].pop_front());
                    m_beat++;
                    if (m_beat == BL) begin
                        sum = m_ptr[m_pod] + BL;
                        if (sum >= REGION) begin
                            sum = sum - REGION;
                            m_wrap[m_pod] = 1'b1;
                        end
                        m_ptr[m_pod] = sum;
                        m_last  = m_pod;
                        m_phase = 0;
                        bursts++;
                    end
                end
            end
        endcase

        if (capture_flush && !clr) m_pend = 1'b1;
        if (trig_rst) model_reset();
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++)
            if (pop_flag[p] && fq[p].size() > 0) void'(fq[p].pop_front());
        if (rnd_ready) begin
            ram_cmd_ready = 1'($urandom_range(0, 1));
            ram_wr_ready  = 1'($urandom_range(0, 1));
        end
        refresh();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic trig_pulse();
        trig_rst = 1'b1;
        ticks(32);
        trig_rst = 1'b0;
        tick();
        bursts  = 0;
        pops[0] = 0;
        pops[1] = 0;
        grants.delete();
    endtask

    initial begin
        int  fd0;
        bit  reached;
        bit  drained;

        rst_n         = 1'b0;
        trig_rst      = 1'b0;
        capture_flush = 1'b0;
        ram_cmd_ready = 1'b1;
        ram_wr_ready  = 1'b1;
        rnd_ready     = 1'b0;
        seq[0] = 0;
        seq[1] = 0;
        fd_cnt = 0;
        bursts = 0;
        pops[0] = 0;
        pops[1] = 0;
        last_idx = -1;
        model_reset();
        refresh();

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_valid", 64'(ram_cmd_valid), 64'd0);
        check("rst_wr_valid", 64'(ram_wr_valid), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        check("rst_wrapped", 64'(wrapped), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_wr_last", 64'(ram_wr_last), 64'd0);
        rst_n = 1'b1;

        // single full burst from pod 0
        push(0, 8);
        ticks(14);
        check("t2_ptr0", 64'(wr_ptr[PW-1:0]), 64'd8);
        check("t2_bursts", 64'(bursts), 64'd1);
        check("t2_pops0", 64'(pops[0]), 64'd8);
        check("t2_last_beat", 64'(last_idx), 64'd7);
        check("t2_ngrants", 64'(grants.size()), 64'd1);
        if (grants.size() > 0) check("t2_grant0", 64'(grants[0]), 64'd0);

        // both pods full: grants alternate starting at pod 0
        trig_pulse();
        push(0, 16);
        push(1, 16);
        ticks(60);
        check("t3_ngrants", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < grants.size()) check("t3_grant_seq", 64'(grants[i]), 64'(i % 2));
        check("t3_ptr0", 64'(wr_ptr[PW-1:0]), 64'd16);
        check("t3_ptr1", 64'(wr_ptr[2*PW-1:PW]), 64'd16);

        // partial drain of pod 1 on flush, second flush while pending ignored
        trig_pulse();
        push(1, 3);
        tick();
        fd0 = fd_cnt;
        capture_flush = 1'b1;
        tick();
        capture_flush = 1'b0;
        ticks(3);
        capture_flush = 1'b1;
        tick();
        capture_flush = 1'b0;
        ticks(25);
        check("t4_flush_pulses", 64'(fd_cnt - fd0), 64'd1);
        check("t4_ptr1", 64'(wr_ptr[2*PW-1:PW]), 64'd8);
        check("t4_pops1", 64'(pops[1]), 64'd3);
        check("t4_bursts", 64'(bursts), 64'd1);

        // trigger reset during beat 4 together with a flush request
        trig_pulse();
        push(0, 8);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (m_phase == 2 && m_beat == 4) reached = 1'b1;
        end
        check("t7_reach_beat4", 64'(reached), 64'd1);
        fd0 = fd_cnt;
        trig_rst      = 1'b1;
        capture_flush = 1'b1;
        tick();
        capture_flush = 1'b0;
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_wr_valid", 64'(ram_wr_valid), 64'd0);
        check("t7_cmd_valid", 64'(ram_cmd_valid), 64'd0);
        check("t7_wr_ptr", 64'(wr_ptr), 64'd0);
        ticks(31);
        trig_rst = 1'b0;
        ticks(20);
        check("t7_no_flush_done", 64'(fd_cnt - fd0), 64'd0);
        for (int p = 0; p < 2; p++) begin
            fq[p].delete();
            eq[p].delete();
        end
        refresh();

        // pod 0 ring-buffer wrap and sticky wrapped flag
        trig_pulse();
        for (int i = 0; i < 63; i++) begin
            push(0, 8);
            ticks(14);
        end
        check("t6_ptr_before", 64'(wr_ptr[PW-1:0]), 64'(REGION - 8));
        check("t6_wrapped_before", 64'(wrapped), 64'd0);
        push(0, 8);
        ticks(14);
        check("t6_ptr_wrap", 64'(wr_ptr[PW-1:0]), 64'd0);
        check("t6_wrapped", 64'(wrapped), 64'b01);
        push(0, 8);
        ticks(14);
        check("t6_ptr_after", 64'(wr_ptr[PW-1:0]), 64'd8);
        check("t6_wrapped_sticky", 64'(wrapped), 64'b01);

        // random traffic with random back-pressure and occasional flushes
        trig_pulse();
        rnd_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++)
                if ($urandom_range(0, 2) == 0 && fq[p].size() < 300) push(p, 1);
            if ($urandom_range(0, 299) == 0) capture_flush = 1'b1;
            tick();
            capture_flush = 1'b0;
        end
        capture_flush = 1'b1;
        tick();
        capture_flush = 1'b0;
        drained = 1'b0;
        for (int i = 0; i < 6000 && !drained; i++) begin
            tick();
            if (fq[0].size() == 0 && fq[1].size() == 0 && m_phase == 0 && !m_pend)
                drained = 1'b1;
        end
        ticks(4);
        check("t5_drained", 64'(drained), 64'd1);
        check("t5_owed0", 64'(eq[0].size()), 64'd0);
        check("t5_owed1", 64'(eq[1].size()), 64'd0);
        check("t5_active", 64'(bursts > 100), 64'd1);
        rnd_ready     = 1'b0;
        ram_cmd_ready = 1'b1;
        ram_wr_ready  = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
